// File: rtl/axil_rd_adapter_if.sv
// AXI4-Lite read-channel bundle (AR + R) shared by the upstream and downstream sides
// of the read adapter.
interface axil_rd_adapter_if #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0] araddr;
    logic                  arvalid;
    logic                  arready;
    logic [DATA_WIDTH-1:0] rdata;
    logic [1:0]            rresp;
    logic                  rvalid;
    logic                  rready;

    modport master (
        output araddr, arvalid, rready,
        input  arready, rdata, rresp, rvalid
    );

    modport slave (
        input  araddr, arvalid, rready,
        output arready, rdata, rresp, rvalid
    );
endinterface

// File: rtl/axil_rd_adapter.sv
// AXI4-Lite read width adapter: one wide upstream read becomes RATIO narrow downstream
// reads whose data lanes and worst-case response are merged into one registered reply.
module axil_rd_adapter #(
    parameter int unsigned ADDR_WIDTH   = 32,
    parameter int unsigned S_DATA_WIDTH = 32,
    parameter int unsigned M_DATA_WIDTH = 32
) (
    input logic               clk,
    input logic               rstn,
    axil_rd_adapter_if.slave  s_axil,
    axil_rd_adapter_if.master m_axil
);
    localparam int unsigned RATIO   = S_DATA_WIDTH / M_DATA_WIDTH;
    localparam int unsigned S_BYTES = S_DATA_WIDTH / 8;
    localparam int unsigned M_BYTES = M_DATA_WIDTH / 8;
    localparam int unsigned CNT_W   = (RATIO > 1) ? $clog2(RATIO) : 1;
    localparam logic [ADDR_WIDTH-1:0] S_MASK = ADDR_WIDTH'(S_BYTES - 1);

    typedef enum logic [1:0] {StIdle, StAddr, StData, StResp} state_e;

    state_e                  state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [1:0]              resp_q, resp_d;
    logic [S_DATA_WIDTH-1:0] acc_q, acc_d;
    logic                    s_arready_q, s_arready_d;
    logic                    s_rvalid_q, s_rvalid_d;
    logic [S_DATA_WIDTH-1:0] s_rdata_q, s_rdata_d;
    logic [1:0]              s_rresp_q, s_rresp_d;
    logic                    m_arvalid_q, m_arvalid_d;
    logic [ADDR_WIDTH-1:0]   m_araddr_q, m_araddr_d;
    logic                    m_rready_q, m_rready_d;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            resp_q      <= '0;
            acc_q       <= '0;
            s_arready_q <= 1'b0;
            s_rvalid_q  <= 1'b0;
            s_rdata_q   <= '0;
            s_rresp_q   <= '0;
            m_arvalid_q <= 1'b0;
            m_araddr_q  <= '0;
            m_rready_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            resp_q      <= resp_d;
            acc_q       <= acc_d;
            s_arready_q <= s_arready_d;
            s_rvalid_q  <= s_rvalid_d;
            s_rdata_q   <= s_rdata_d;
            s_rresp_q   <= s_rresp_d;
            m_arvalid_q <= m_arvalid_d;
            m_araddr_q  <= m_araddr_d;
            m_rready_q  <= m_rready_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        resp_d      = resp_q;
        acc_d       = acc_q;
        s_arready_d = s_arready_q;
        s_rvalid_d  = s_rvalid_q;
        s_rdata_d   = s_rdata_q;
        s_rresp_d   = s_rresp_q;
        m_arvalid_d = m_arvalid_q;
        m_araddr_d  = m_araddr_q;
        m_rready_d  = m_rready_q;

        case (state_q)
            StIdle: begin
                s_arready_d = !s_rvalid_q;
                if (s_axil.arvalid && s_arready_q) begin
                    s_arready_d = 1'b0;
                    m_arvalid_d = 1'b1;
                    m_araddr_d  = s_axil.araddr & ~S_MASK;
                    cnt_d       = '0;
                    resp_d      = 2'b00;
                    state_d     = StAddr;
                end
            end
            StAddr: begin
                if (m_axil.arready) begin
                    m_arvalid_d = 1'b0;
                    m_rready_d  = 1'b1;
                    state_d     = StData;
                end
            end
            StData: begin
                if (m_axil.rvalid) begin
                    m_rready_d = 1'b0;
                    for (int unsigned i = 0; i < RATIO; i++) begin
                        if (cnt_q == CNT_W'(i)) begin
                            acc_d[i*M_DATA_WIDTH +: M_DATA_WIDTH] = m_axil.rdata;
                        end
                    end
                    // Numeric max ranks DECERR over SLVERR over OKAY.
                    if (m_axil.rresp > resp_q) begin
                        resp_d = m_axil.rresp;
                    end
                    if (cnt_q == CNT_W'(RATIO - 1)) begin
                        s_rvalid_d = 1'b1;
                        s_rdata_d  = acc_d;
                        s_rresp_d  = resp_d;
                        state_d    = StResp;
                    end else begin
                        cnt_d       = cnt_q + CNT_W'(1);
                        m_arvalid_d = 1'b1;
                        m_araddr_d  = m_araddr_q + ADDR_WIDTH'(M_BYTES);
                        state_d     = StAddr;
                    end
                end
            end
            StResp: begin
                if (s_axil.rready) begin
                    s_rvalid_d  = 1'b0;
                    s_arready_d = 1'b1;
                    state_d     = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    assign s_axil.arready = s_arready_q;
    assign s_axil.rvalid  = s_rvalid_q;
    assign s_axil.rdata   = s_rdata_q;
    assign s_axil.rresp   = s_rresp_q;
    assign m_axil.arvalid = m_arvalid_q;
    assign m_axil.araddr  = m_araddr_q;
    assign m_axil.rready  = m_rready_q;
endmodule

// File: tb/tb_axil_rd_adapter.sv
// Bench for axil_rd_adapter: 64->32 instance behind a narrow-slave model with a response
// scoreboard and protocol monitors, plus a 32->32 pass-through instance.
module tb_axil_rd_adapter;
    localparam int unsigned AW = 32;
    localparam int unsigned SW = 64;
    localparam int unsigned MW = 32;

    logic clk = 1'b0;
    logic rstn = 1'b0;
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    axil_rd_adapter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(SW)) s_if ();
    axil_rd_adapter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(MW)) m_if ();
    axil_rd_adapter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(32)) s2_if ();
    axil_rd_adapter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(32)) m2_if ();

    axil_rd_adapter #(.ADDR_WIDTH(AW), .S_DATA_WIDTH(SW), .M_DATA_WIDTH(MW)) dut (
        .clk    (clk),
        .rstn   (rstn),
        .s_axil (s_if),
        .m_axil (m_if)
    );

    axil_rd_adapter #(.ADDR_WIDTH(AW), .S_DATA_WIDTH(32), .M_DATA_WIDTH(32)) dut2 (
        .clk    (clk),
        .rstn   (rstn),
        .s_axil (s2_if),
        .m_axil (m2_if)
    );

    // Zero-wait downstream for the pass-through instance.
    assign m2_if.arready = 1'b1;
    assign m2_if.rvalid  = m2_if.rready;
    assign m2_if.rdata   = 32'hDEAD_BEEF;
    assign m2_if.rresp   = 2'b00;

    typedef struct packed {
        logic [31:0] data;
        logic [1:0]  resp;
    } beat_t;

    typedef struct packed {
        logic [63:0] data;
        logic [1:0]  resp;
    } rsp_t;

    typedef struct {
        logic [31:0] addr;
        beat_t       b0;
        beat_t       b1;
        logic [31:0] base;
        logic [63:0] rdata;
        logic [1:0]  rresp;
    } vec_t;

    beat_t       m_beats[$];
    rsp_t        sb[$];
    logic [31:0] m_addr_log[$];
    int          ar_delay_cfg = 0;
    int          r_delay_cfg = 0;
    int          rsp_cnt = 0;
    int          last_rsp_cyc = 0;
    int          rise_cyc = 0;

    function automatic void chk(input string name, input logic [63:0] act,
                                input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endfunction

    function automatic logic [31:0] dflt_data(input logic [31:0] a);
        return a ^ 32'h5A5A_0000;
    endfunction

    // Narrow-slave model: configurable AR and R wait states, data from m_beats or address.
    bit          mdl_ar_hs, mdl_r_hs, mdl_rst, mdl_pend;
    int          mdl_ar_wait, mdl_r_wait;
    logic [31:0] mdl_addr;
    beat_t       mdl_cur;

    initial begin
        m_if.arready = 1'b0;
        m_if.rvalid  = 1'b0;
        m_if.rdata   = '0;
        m_if.rresp   = '0;
        mdl_pend     = 1'b0;
        mdl_ar_wait  = 0;
        mdl_r_wait   = 0;
        mdl_cur      = '0;
        forever begin
            @(negedge clk);
            mdl_ar_hs = m_if.arvalid && m_if.arready;
            mdl_r_hs  = m_if.rvalid && m_if.rready;
            mdl_rst   = !rstn;
            mdl_addr  = m_if.araddr;
            @(posedge clk);
            #1;
            if (mdl_rst) begin
                mdl_pend     = 1'b0;
                m_if.arready = 1'b0;
                m_if.rvalid  = 1'b0;
                mdl_ar_wait  = ar_delay_cfg;
            end else begin
                if (mdl_r_hs) begin
                    mdl_pend    = 1'b0;
                    m_if.rvalid = 1'b0;
                end
                if (mdl_ar_hs) begin
                    m_addr_log.push_back(mdl_addr);
                    if (m_beats.size() != 0) mdl_cur = m_beats.pop_front();
                    else mdl_cur = '{data: dflt_data(mdl_addr), resp: 2'b00};
                    mdl_pend    = 1'b1;
                    mdl_r_wait  = r_delay_cfg;
                    mdl_ar_wait = ar_delay_cfg;
                end
                if (mdl_pend) begin
                    m_if.arready = 1'b0;
                    if (!m_if.rvalid) begin
                        if (mdl_r_wait > 0) mdl_r_wait--;
                        else begin
                            m_if.rvalid = 1'b1;
                            m_if.rdata  = mdl_cur.data;
                            m_if.rresp  = mdl_cur.resp;
                        end
                    end
                end else if (m_if.arvalid) begin
                    if (mdl_ar_wait > 0) begin
                        mdl_ar_wait--;
                        m_if.arready = 1'b0;
                    end else begin
                        m_if.arready = 1'b1;
                    end
                end else begin
                    mdl_ar_wait  = ar_delay_cfg;
                    m_if.arready = 1'b0;
                end
            end
        end
    end

    // Protocol monitors and scoreboard consumer.
    logic        p_m_arvalid, p_m_arready, p_s_rvalid, p_s_rready;
    logic [31:0] p_m_araddr;
    logic [63:0] p_s_rdata;
    logic [1:0]  p_s_rresp;
    rsp_t        exp_r;

    always @(negedge clk) begin
        if (!rstn) begin
            p_m_arvalid = 1'b0;
            p_m_arready = 1'b0;
            p_s_rvalid  = 1'b0;
            p_s_rready  = 1'b0;
            p_m_araddr  = '0;
            p_s_rdata   = '0;
            p_s_rresp   = '0;
        end else begin
            if (m_if.rready) chk("m_rready_with_arvalid", 64'(m_if.arvalid), 64'd0);
            if (p_m_arvalid && !p_m_arready) begin
                chk("m_arvalid_held", 64'(m_if.arvalid), 64'd1);
                chk("m_araddr_held", 64'(m_if.araddr), 64'(p_m_araddr));
            end
            if (p_s_rvalid && !p_s_rready) begin
                chk("s_rvalid_held", 64'(s_if.rvalid), 64'd1);
                chk("s_rdata_held", s_if.rdata, p_s_rdata);
                chk("s_rresp_held", 64'(s_if.rresp), 64'(p_s_rresp));
            end
            if (m_if.arvalid || m_if.rready || s_if.rvalid)
                chk("s_arready_busy", 64'(s_if.arready), 64'd0);
            if (s_if.rvalid && !p_s_rvalid) rise_cyc = cyc;
            if (s_if.rvalid && s_if.rready) begin
                chk("sb_has_entry", 64'(sb.size() != 0), 64'd1);
                if (sb.size() != 0) begin
                    exp_r = sb.pop_front();
                    chk("s_rdata", s_if.rdata, exp_r.data);
                    chk("s_rresp", 64'(s_if.rresp), 64'(exp_r.resp));
                end
                rsp_cnt++;
                last_rsp_cyc = cyc;
            end
            p_m_arvalid = m_if.arvalid;
            p_m_arready = m_if.arready;
            p_m_araddr  = m_if.araddr;
            p_s_rvalid  = s_if.rvalid;
            p_s_rready  = s_if.rready;
            p_s_rdata   = s_if.rdata;
            p_s_rresp   = s_if.rresp;
        end
    end

    task automatic s_issue(input logic [31:0] addr, output int hs);
        s_if.araddr  = addr;
        s_if.arvalid = 1'b1;
        hs = -1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (s_if.arready) begin
                hs = cyc;
                break;
            end
            @(posedge clk);
            #1;
        end
        if (hs < 0) chk("s_ar_handshake", 64'(s_if.arready), 64'd1);
        @(posedge clk);
        #1;
        s_if.arvalid = 1'b0;
    endtask

    task automatic wait_rsp(input int target);
        for (int i = 0; i < 200 && rsp_cnt < target; i++) @(negedge clk);
        if (rsp_cnt < target) chk("rsp_timeout", 64'(rsp_cnt), 64'(target));
        @(posedge clk);
        #1;
    endtask

    task automatic chk_log2(input string name, input logic [31:0] base);
        chk({name, "_nreads"}, 64'(m_addr_log.size()), 64'd2);
        if (m_addr_log.size() == 2) begin
            chk({name, "_addr0"}, 64'(m_addr_log[0]), 64'(base));
            chk({name, "_addr1"}, 64'(m_addr_log[1]), 64'(base + 32'd4));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    vec_t        vecs[6];
    int          hs, hs2, n, r1, rise2;
    logic [31:0] m2_addr;
    logic [31:0] s2_data;
    logic [1:0]  s2_resp;

    initial begin
        vecs[0] = '{32'h0000_1004, '{32'h1111_1111, 2'd0}, '{32'h2222_2222, 2'd0},
                    32'h0000_1000, 64'h2222_2222_1111_1111, 2'd0};
        vecs[1] = '{32'h0000_1008, '{32'hAAAA_0000, 2'd2}, '{32'h0000_BBBB, 2'd0},
                    32'h0000_1008, 64'h0000_BBBB_AAAA_0000, 2'd2};
        vecs[2] = '{32'h0000_1010, '{32'h1234_5678, 2'd2}, '{32'h9ABC_DEF0, 2'd3},
                    32'h0000_1010, 64'h9ABC_DEF0_1234_5678, 2'd3};
        vecs[3] = '{32'h0000_0FFC, '{32'hCAFE_F00D, 2'd1}, '{32'h0000_0000, 2'd0},
                    32'h0000_0FF8, 64'h0000_0000_CAFE_F00D, 2'd1};
        vecs[4] = '{32'h0000_1017, '{32'h0000_0003, 2'd0}, '{32'h0000_0001, 2'd2},
                    32'h0000_1010, 64'h0000_0001_0000_0003, 2'd2};
        vecs[5] = '{32'hFFFF_FFFD, '{32'h0F0F_0F0F, 2'd3}, '{32'hF0F0_F0F0, 2'd1},
                    32'hFFFF_FFF8, 64'hF0F0_F0F0_0F0F_0F0F, 2'd3};

        s_if.araddr   = '0;
        s_if.arvalid  = 1'b0;
        s_if.rready   = 1'b1;
        s2_if.araddr  = '0;
        s2_if.arvalid = 1'b0;
        s2_if.rready  = 1'b1;
        rstn = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_s_arready", 64'(s_if.arready), 64'd0);
        chk("rst_s_rvalid", 64'(s_if.rvalid), 64'd0);
        chk("rst_s_rdata", s_if.rdata, 64'd0);
        chk("rst_s_rresp", 64'(s_if.rresp), 64'd0);
        chk("rst_m_arvalid", 64'(m_if.arvalid), 64'd0);
        chk("rst_m_araddr", 64'(m_if.araddr), 64'd0);
        chk("rst_m_rready", 64'(m_if.rready), 64'd0);
        chk("rst_s2_arready", 64'(s2_if.arready), 64'd0);
        @(posedge clk);
        #1;
        rstn = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("post_rst_arready", 64'(s_if.arready), 64'd1);
        @(posedge clk);
        #1;

        // Table: zero-wait downstream, data/resp merge, alignment and address wrap.
        for (int v = 0; v < 6; v++) begin
            m_addr_log.delete();
            m_beats.push_back(vecs[v].b0);
            m_beats.push_back(vecs[v].b1);
            sb.push_back('{data: vecs[v].rdata, resp: vecs[v].rresp});
            n = rsp_cnt;
            s_issue(vecs[v].addr, hs);
            wait_rsp(n + 1);
            chk($sformatf("v%0d_latency", v), 64'(rise_cyc - hs), 64'd5);
            chk_log2($sformatf("v%0d", v), vecs[v].base);
        end

        // Downstream and upstream back-pressure.
        ar_delay_cfg = 3;
        r_delay_cfg  = 2;
        s_if.rready  = 1'b0;
        m_addr_log.delete();
        m_beats.push_back('{data: 32'h0102_0304, resp: 2'd0});
        m_beats.push_back('{data: 32'h0506_0708, resp: 2'd0});
        sb.push_back('{data: 64'h0506_0708_0102_0304, resp: 2'd0});
        n = rsp_cnt;
        s_issue(32'h0000_3000, hs);
        for (int i = 0; i < 200 && !s_if.rvalid; i++) @(negedge clk);
        chk("bp_rvalid_seen", 64'(s_if.rvalid), 64'd1);
        repeat (4) @(negedge clk);
        chk("bp_rvalid_held", 64'(s_if.rvalid), 64'd1);
        chk("bp_arready_low", 64'(s_if.arready), 64'd0);
        @(posedge clk);
        #1;
        s_if.rready  = 1'b1;
        wait_rsp(n + 1);
        ar_delay_cfg = 0;
        r_delay_cfg  = 0;
        chk_log2("bp", 32'h0000_3000);

        // Reset while waiting for downstream data abandons the transaction.
        r_delay_cfg = 3;
        s_issue(32'h0000_2000, hs);
        for (int i = 0; i < 50 && !m_if.rready; i++) @(negedge clk);
        chk("mid_in_data", 64'(m_if.rready), 64'd1);
        @(posedge clk);
        #1;
        rstn = 1'b0;
        @(posedge clk);
        #1;
        rstn = 1'b1;
        @(negedge clk);
        chk("mid_rst_s_arready", 64'(s_if.arready), 64'd0);
        chk("mid_rst_s_rvalid", 64'(s_if.rvalid), 64'd0);
        chk("mid_rst_m_arvalid", 64'(m_if.arvalid), 64'd0);
        chk("mid_rst_m_rready", 64'(m_if.rready), 64'd0);
        chk("mid_rst_s_rdata", s_if.rdata, 64'd0);
        r_delay_cfg = 0;
        m_beats.delete();
        @(posedge clk);
        #1;
        m_addr_log.delete();
        sb.push_back('{data: {dflt_data(32'h2004), dflt_data(32'h2000)}, resp: 2'd0});
        n = rsp_cnt;
        s_issue(32'h0000_2000, hs);
        wait_rsp(n + 1);
        chk("after_rst_rsp_cnt", 64'(rsp_cnt), 64'(n + 1));
        chk_log2("after_rst", 32'h0000_2000);

        // Back-to-back reads with upstream always ready.
        m_addr_log.delete();
        sb.push_back('{data: {dflt_data(32'h4), dflt_data(32'h0)}, resp: 2'd0});
        sb.push_back('{data: {dflt_data(32'hC), dflt_data(32'h8)}, resp: 2'd0});
        n = rsp_cnt;
        s_issue(32'h0000_0000, hs);
        s_issue(32'h0000_0008, hs2);
        r1 = last_rsp_cyc;
        chk("b2b_first_rsp_done", 64'(rsp_cnt), 64'(n + 1));
        chk("b2b_arready_gap", 64'(hs2), 64'(r1 + 1));
        wait_rsp(n + 2);
        chk("b2b_nreads", 64'(m_addr_log.size()), 64'd4);
        for (int i = 0; i < 4; i++) begin
            if (i < m_addr_log.size())
                chk($sformatf("b2b_addr%0d", i), 64'(m_addr_log[i]), 64'(4 * i));
        end

        // Pass-through instance at the top of the address space.
        s2_if.araddr  = 32'hFFFF_FFFC;
        s2_if.arvalid = 1'b1;
        hs = -1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (s2_if.arready) begin
                hs = cyc;
                break;
            end
            @(posedge clk);
            #1;
        end
        chk("pt_ar_handshake", 64'(hs >= 0), 64'd1);
        @(posedge clk);
        #1;
        s2_if.arvalid = 1'b0;
        m2_addr = '0;
        s2_data = '0;
        s2_resp = 2'b11;
        rise2   = -1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (m2_if.arvalid && m2_if.arready) m2_addr = m2_if.araddr;
            if (s2_if.rvalid) begin
                rise2   = cyc;
                s2_data = s2_if.rdata;
                s2_resp = s2_if.rresp;
                break;
            end
        end
        chk("pt_m_araddr", 64'(m2_addr), 64'hFFFF_FFFC);
        chk("pt_s_rdata", 64'(s2_data), 64'hDEAD_BEEF);
        chk("pt_s_rresp", 64'(s2_resp), 64'd0);
        chk("pt_latency", 64'(rise2 - hs), 64'd3);
        @(posedge clk);
        #1;

        chk("sb_drained", 64'(sb.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
